// File: rtl/regfile_sb.sv
// Parametrised register file with configurable read ports, byte-enabled writes,
// same-cycle write-to-read bypass and a per-register busy scoreboard.
module regfile_sb #(
  parameter int                DATA_W  = 32,
  parameter int                ADDR_W  = 5,
  parameter int                NUM_RD  = 2,
  parameter int                SP_IDX  = 29,
  parameter logic [DATA_W-1:0] SP_INIT = 'h7ff
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [DATA_W/8-1:0]      wr_be,
  input  logic                     sb_set,
  input  logic [ADDR_W-1:0]        sb_addr,
  input  logic                     flush
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int NB    = DATA_W / 8;

  // Register 0 is hard-wired to zero, so only 1..DEPTH-1 exist.
  logic [DATA_W-1:0] regs [1:DEPTH-1];
  logic [DEPTH-1:1]  busy;

  logic wr_hit_any;
  logic set_hit_any;
  assign wr_hit_any  = we && (wr_addr != '0);
  assign set_hit_any = sb_set && (sb_addr != '0);

  // Interface timing: there is no valid/ready handshake; every input is
  // sampled at every rising edge and all reads are combinational.

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 1; i < DEPTH; i++) begin
        regs[i] <= (i == SP_IDX) ? SP_INIT : '0;
      end
    end else if (wr_hit_any) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_be[b]) begin
          regs[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
      end
    end
  end

  // Flush beats set; set beats a writeback clear on the same register
  // because the newly issued producer supersedes the retiring one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= '0;
    end else if (flush) begin
      busy <= '0;
    end else begin
      if (wr_hit_any && !(set_hit_any && (sb_addr == wr_addr))) begin
        busy[wr_addr] <= 1'b0;
      end
      if (set_hit_any) begin
        busy[sb_addr] <= 1'b1;
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] stored;
    logic [DATA_W-1:0] merged;
    logic              hit;

    assign addr   = rd_addr[k*ADDR_W +: ADDR_W];
    assign stored = (addr == '0) ? '0 : regs[addr];
    assign hit    = wr_hit_any && (wr_addr == addr);

    always_comb begin
      merged = stored;
      for (int b = 0; b < NB; b++) begin
        if (hit && wr_be[b]) begin
          merged[b*8 +: 8] = wr_data[b*8 +: 8];
        end
      end
    end

    // A bypass hit means the value is arriving now, so it is not pending.
    assign rd_data[k*DATA_W +: DATA_W] = merged;
    assign rd_busy[k] = (addr != '0) && !hit && busy[addr];
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: a 32x32 two-port instance and a 16x64
// four-port instance, checked through an expected-value queue.
module tb_regfile_sb;

  logic clk;
  logic reset;

  // Instance A: default parameters.
  logic [9:0]  a_rd_addr;
  logic [63:0] a_rd_data;
  logic [1:0]  a_rd_busy;
  logic        a_we;
  logic [4:0]  a_wr_addr;
  logic [31:0] a_wr_data;
  logic [3:0]  a_wr_be;
  logic        a_sb_set;
  logic [4:0]  a_sb_addr;
  logic        a_flush;

  // Instance B: four ports, 16 x 64-bit.
  logic [15:0]  b_rd_addr;
  logic [255:0] b_rd_data;
  logic [3:0]   b_rd_busy;
  logic         b_we;
  logic [3:0]   b_wr_addr;
  logic [63:0]  b_wr_data;
  logic [7:0]   b_wr_be;
  logic         b_sb_set;
  logic [3:0]   b_sb_addr;
  logic         b_flush;

  regfile_sb u_dut_a (
    .clk     (clk),
    .reset   (reset),
    .rd_addr (a_rd_addr),
    .rd_data (a_rd_data),
    .rd_busy (a_rd_busy),
    .we      (a_we),
    .wr_addr (a_wr_addr),
    .wr_data (a_wr_data),
    .wr_be   (a_wr_be),
    .sb_set  (a_sb_set),
    .sb_addr (a_sb_addr),
    .flush   (a_flush)
  );

  regfile_sb #(
    .DATA_W  (64),
    .ADDR_W  (4),
    .NUM_RD  (4),
    .SP_IDX  (13),
    .SP_INIT (64'h7ff)
  ) u_dut_b (
    .clk     (clk),
    .reset   (reset),
    .rd_addr (b_rd_addr),
    .rd_data (b_rd_data),
    .rd_busy (b_rd_busy),
    .we      (b_we),
    .wr_addr (b_wr_addr),
    .wr_data (b_wr_data),
    .wr_be   (b_wr_be),
    .sb_set  (b_sb_set),
    .sb_addr (b_sb_addr),
    .flush   (b_flush)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard
  logic [63:0] exp_q[$];
  int n_cmp;
  int n_err;

  task automatic push_exp(input logic [63:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [63:0] obs);
    logic [63:0] e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $error("FAIL %s: observed %h, no expected value queued", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_err++;
        $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_idle();
    a_we = 1'b0; a_wr_addr = '0; a_wr_data = '0; a_wr_be = '0;
    a_sb_set = 1'b0; a_sb_addr = '0; a_flush = 1'b0;
  endtask

  task automatic a_write(input logic [4:0] ad, input logic [31:0] d, input logic [3:0] be);
    a_we = 1'b1; a_wr_addr = ad; a_wr_data = d; a_wr_be = be;
  endtask

  task automatic a_set(input logic [4:0] ad);
    a_sb_set = 1'b1; a_sb_addr = ad;
  endtask

  task automatic a_read(input logic [4:0] p0, input logic [4:0] p1);
    a_rd_addr = {p1, p0};
    #1;
  endtask

  initial begin
    logic [4:0] ai;
    logic [3:0] bi;
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    a_idle();
    a_rd_addr = '0;
    b_rd_addr = '0;
    b_we = 1'b0; b_wr_addr = '0; b_wr_data = '0; b_wr_be = '0;
    b_sb_set = 1'b0; b_sb_addr = '0; b_flush = 1'b0;
    repeat (2) tick();
    reset = 1'b0;

    // Random prior state, then an asynchronous reset mid-cycle.
    for (int i = 0; i < 10; i++) begin
      a_write(5'($urandom_range(1, 31)), $urandom, 4'hf);
      a_set(5'($urandom_range(1, 31)));
      tick();
    end
    reset = 1'b1;
    a_idle();
    #1;
    for (int i = 0; i < 32; i++) begin
      ai = 5'(i);
      a_read(ai, ai);
      push_exp((i == 29) ? 64'h7ff : 64'h0);
      check($sformatf("reset_p0_r%0d", i), {32'h0, a_rd_data[31:0]});
      push_exp((i == 29) ? 64'h7ff : 64'h0);
      check($sformatf("reset_p1_r%0d", i), {32'h0, a_rd_data[63:32]});
      push_exp(64'h0);
      check($sformatf("reset_busy_r%0d", i), {62'h0, a_rd_busy});
    end
    tick();
    reset = 1'b0;

    // Byte-enabled write with bypass.
    a_write(5'd5, 32'hffff_ffff, 4'b1111);
    tick();
    a_write(5'd5, 32'h1234_5678, 4'b0101);
    a_read(5'd5, 5'd5);
    push_exp(64'hff34_ff78);
    check("be_bypass_p0", {32'h0, a_rd_data[31:0]});
    push_exp(64'hff34_ff78);
    check("be_bypass_p1", {32'h0, a_rd_data[63:32]});
    tick();
    a_idle();
    #1;
    push_exp(64'hff34_ff78);
    check("be_stored", {32'h0, a_rd_data[31:0]});

    // Register zero ignores writes and scoreboard sets.
    a_write(5'd0, 32'hdead_beef, 4'hf);
    a_set(5'd0);
    a_read(5'd0, 5'd0);
    push_exp(64'h0);
    check("r0_same_cycle_data", {32'h0, a_rd_data[31:0]});
    push_exp(64'h0);
    check("r0_same_cycle_busy", {62'h0, a_rd_busy});
    tick();
    a_idle();
    #1;
    push_exp(64'h0);
    check("r0_after_data", a_rd_data);
    push_exp(64'h0);
    check("r0_after_busy", {62'h0, a_rd_busy});

    // Scoreboard lifecycle on reg7.
    a_set(5'd7);
    a_read(5'd7, 5'd7);
    push_exp(64'h0);
    check("sb7_before_edge", {63'h0, a_rd_busy[0]});
    tick();
    a_idle();
    #1;
    push_exp(64'h1);
    check("sb7_n1", {63'h0, a_rd_busy[0]});
    tick();
    tick();
    push_exp(64'h1);
    check("sb7_n2", {63'h0, a_rd_busy[0]});
    a_write(5'd7, 32'h0000_00a5, 4'hf);
    #1;
    push_exp(64'h0);
    check("sb7_wb_busy", {63'h0, a_rd_busy[0]});
    push_exp(64'ha5);
    check("sb7_wb_bypass", {32'h0, a_rd_data[31:0]});
    tick();
    a_idle();
    #1;
    push_exp(64'h0);
    check("sb7_after_busy", {63'h0, a_rd_busy[0]});
    push_exp(64'ha5);
    check("sb7_after_data", {32'h0, a_rd_data[31:0]});

    // Set and writeback together: same address keeps busy, different both act.
    a_set(5'd9);
    tick();
    a_set(5'd9);
    a_write(5'd9, 32'h9999_9999, 4'hf);
    a_read(5'd9, 5'd10);
    push_exp(64'h0);
    check("sb9_hit_busy", {63'h0, a_rd_busy[0]});
    tick();
    a_idle();
    #1;
    push_exp(64'h1);
    check("sb9_set_wins", {63'h0, a_rd_busy[0]});
    a_set(5'd10);
    a_write(5'd9, 32'h1, 4'h0);
    tick();
    a_idle();
    #1;
    push_exp(64'h2);
    check("sb9_clr_sb10_set", {62'h0, a_rd_busy});
    push_exp(64'h9999_9999);
    check("sb9_be0_keeps_data", {32'h0, a_rd_data[31:0]});

    // Flush beats a simultaneous set.
    a_set(5'd3);
    tick();
    a_set(5'd4);
    tick();
    a_idle();
    a_read(5'd3, 5'd4);
    push_exp(64'h3);
    check("flush_pre_busy", {62'h0, a_rd_busy});
    a_flush = 1'b1;
    a_set(5'd6);
    tick();
    a_idle();
    a_read(5'd3, 5'd4);
    push_exp(64'h0);
    check("flush_r3_r4", {62'h0, a_rd_busy});
    a_read(5'd6, 5'd10);
    push_exp(64'h0);
    check("flush_r6_r10", {62'h0, a_rd_busy});

    // Four ports reading a register under a partial write.
    b_we = 1'b1; b_wr_addr = 4'd5; b_wr_data = 64'h1111_2222_3333_4444; b_wr_be = 8'hff;
    tick();
    b_wr_data = 64'haaaa_bbbb_cccc_dddd; b_wr_be = 8'h0f;
    b_rd_addr = {4{4'd5}};
    #1;
    for (int k = 0; k < 4; k++) begin
      push_exp(64'h1111_2222_cccc_dddd);
      check($sformatf("mp_bypass_p%0d", k), b_rd_data[k*64 +: 64]);
    end
    tick();
    b_we = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      push_exp(64'h1111_2222_cccc_dddd);
      check($sformatf("mp_stored_p%0d", k), b_rd_data[k*64 +: 64]);
    end

    // Burst of writes and sets, interrupted by reset.
    for (int i = 0; i < 6; i++) begin
      b_we = 1'b1;
      b_wr_addr = 4'($urandom_range(1, 15));
      b_wr_data = {$urandom, $urandom};
      b_wr_be = 8'($urandom_range(1, 255));
      b_sb_set = 1'b1;
      b_sb_addr = 4'($urandom_range(1, 15));
      tick();
    end
    reset = 1'b1;
    b_we = 1'b0; b_sb_set = 1'b0;
    #1;
    for (int i = 0; i < 16; i++) begin
      bi = 4'(i);
      b_rd_addr = {4{bi}};
      #1;
      for (int k = 0; k < 4; k++) begin
        push_exp((i == 13) ? 64'h7ff : 64'h0);
        check($sformatf("mp_reset_r%0d_p%0d", i, k), b_rd_data[k*64 +: 64]);
      end
      push_exp(64'h0);
      check($sformatf("mp_reset_busy_r%0d", i), {60'h0, b_rd_busy});
    end

    // Final report
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL queue_drain: observed %0d leftover entries expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
